// File: rtl/dco_frac.sv
// Fractional-N digitally controlled oscillator for the ADPLL loop.
// Tunable integer period with a fractional accumulator and optional reference alignment.
module dco_frac #(
   parameter int CNT_W       = 10,
   parameter int FRAC_W      = 8,
   parameter int STEP_W      = 4,
   parameter int INIT_PERIOD = 100,
   parameter int MIN_PERIOD  = 4,
   parameter int MAX_PERIOD  = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tune_valid,
   input  logic              tune_dir,
   input  logic [STEP_W-1:0] tune_step,
   input  logic [FRAC_W-1:0] frac_word,
   input  logic              ref_rise,
   input  logic [CNT_W-1:0]  ref_period,
   input  logic              align_en,
   input  logic              out_en,
   output logic              dco_out,
   output logic              dco_tick,
   output logic [CNT_W-1:0]  period_int,
   output logic              sat_hi,
   output logic              sat_lo,
   output logic              ref_too_slow
);

   localparam int XW = CNT_W + 1;

   logic [CNT_W-1:0]  p;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  len;
   logic [CNT_W-1:0]  half;
   logic [FRAC_W-1:0] acc;
   logic              carry;

   logic [XW-1:0]     p_x;
   logic [XW-1:0]     step_x;
   logic [XW-1:0]     sum;
   logic [XW-1:0]     dif;
   logic [XW-1:0]     tuned;
   logic [FRAC_W:0]   acc_sum;
   logic [CNT_W-1:0]  len_nxt;
   logic              wrap;
   logic              align;
   logic              start;

   assign ref_too_slow = {ref_period, 1'b0} <= {1'b0, p};

   assign wrap    = cnt == (len - 1'b1);
   assign align   = align_en && ref_rise && !ref_too_slow;
   assign start   = wrap || align;
   assign len_nxt = p + CNT_W'(carry);
   assign acc_sum = {1'b0, acc} + {1'b0, frac_word};

   assign p_x    = {1'b0, p};
   assign step_x = XW'(tune_step);
   assign sum    = p_x + step_x;
   assign dif    = p_x - step_x;

   // Saturating tune; a step larger than P is treated as underflow.
   always_comb begin
      tuned = p_x;
      if (tune_dir) begin
         tuned = (sum > XW'(MAX_PERIOD)) ? XW'(MAX_PERIOD) : sum;
      end else begin
         if (step_x > p_x || dif < XW'(MIN_PERIOD))
            tuned = XW'(MIN_PERIOD);
         else
            tuned = dif;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p <= CNT_W'(INIT_PERIOD);
      end else if (tune_valid) begin
         p <= tuned[CNT_W-1:0];
      end
   end

   // Align restart wins over wrap and never advances the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         len   <= CNT_W'(INIT_PERIOD);
         half  <= CNT_W'(INIT_PERIOD >> 1);
         acc   <= '0;
         carry <= 1'b0;
      end else if (start) begin
         cnt  <= '0;
         len  <= len_nxt;
         half <= len_nxt >> 1;
         if (!align) begin
            acc   <= acc_sum[FRAC_W-1:0];
            carry <= acc_sum[FRAC_W];
         end
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dco_out  <= 1'b1;
         dco_tick <= 1'b0;
      end else begin
         dco_out  <= out_en && !ref_too_slow && (cnt < half);
         dco_tick <= start;
      end
   end

   assign period_int = p;
   assign sat_hi     = p == CNT_W'(MAX_PERIOD);
   assign sat_lo     = p == CNT_W'(MIN_PERIOD);

endmodule

// File: tb/tb_dco_frac.sv
// Directed bench for dco_frac: free run, fractional periods, tuning,
// saturation, reference alignment and mid-period reset.
module tb_dco_frac;

   logic       clk;
   logic       rst_n;
   logic       tune_valid;
   logic       tune_dir;
   logic [3:0] tune_step;
   logic [7:0] frac_word;
   logic       ref_rise;
   logic [9:0] ref_period;
   logic       align_en;
   logic       out_en;
   logic       dco_out;
   logic       dco_tick;
   logic [9:0] period_int;
   logic       sat_hi;
   logic       sat_lo;
   logic       ref_too_slow;

   int tests = 0;
   int fails = 0;
   int per;
   int hi;
   int n;
   int total;

   dco_frac #(
      .CNT_W(10),
      .FRAC_W(8),
      .STEP_W(4),
      .INIT_PERIOD(100),
      .MIN_PERIOD(4),
      .MAX_PERIOD(120)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tune_valid(tune_valid),
      .tune_dir(tune_dir),
      .tune_step(tune_step),
      .frac_word(frac_word),
      .ref_rise(ref_rise),
      .ref_period(ref_period),
      .align_en(align_en),
      .out_en(out_en),
      .dco_out(dco_out),
      .dco_tick(dco_tick),
      .period_int(period_int),
      .sat_hi(sat_hi),
      .sat_lo(sat_lo),
      .ref_too_slow(ref_too_slow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic tune(input logic dir, input logic [3:0] amt);
      tune_valid = 1'b1;
      tune_dir   = dir;
      tune_step  = amt;
      step(1);
      tune_valid = 1'b0;
   endtask

   // Steps until a tick is sampled; bounded.
   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         step(1);
         cyc++;
      end while (!dco_tick && cyc < 3000);
   endtask

   // Measures one full period starting at a tick; leaves the bench
   // sitting on the tick that begins the following period.
   task automatic measure(output int len, output int high);
      int w;
      if (!dco_tick) wait_tick(w);
      len  = 0;
      high = 0;
      do begin
         if (dco_out) high++;
         len++;
         step(1);
      end while (!dco_tick && len < 3000);
   endtask

   initial begin
      rst_n      = 1'b0;
      tune_valid = 1'b0;
      tune_dir   = 1'b0;
      tune_step  = '0;
      frac_word  = '0;
      ref_rise   = 1'b0;
      ref_period = 10'd100;
      align_en   = 1'b0;
      out_en     = 1'b1;

      #12;
      chk("rst_period", period_int, 100);
      chk("rst_out", dco_out, 1);
      chk("rst_tick", dco_tick, 0);
      chk("rst_sat_hi", sat_hi, 0);
      chk("rst_sat_lo", sat_lo, 0);
      chk("rst_slow", ref_too_slow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      measure(per, hi);
      chk("free_per0", per, 100);
      chk("free_hi0", hi, 50);
      measure(per, hi);
      chk("free_per1", per, 100);
      chk("free_hi1", hi, 50);

      frac_word = 8'd128;
      repeat (3) measure(per, hi);
      measure(per, hi);
      chk("frac_long", per, 101);
      measure(per, hi);
      chk("frac_short", per, 100);
      total = 0;
      for (int i = 0; i < 64; i++) begin
         measure(per, hi);
         total += per;
      end
      chk("frac_sum64", total, 6432);
      frac_word = 8'd0;
      measure(per, hi);
      chk("frac_tail", per, 101);

      step(30);
      tune(1'b1, 4'd5);
      chk("tune_p", period_int, 105);
      wait_tick(n);
      chk("tune_cur_period", n, 69);
      measure(per, hi);
      chk("tune_next_period", per, 105);

      tune(1'b1, 4'd13);
      chk("sat_p118", period_int, 118);
      chk("sat_hi_off", sat_hi, 0);
      tune(1'b1, 4'd5);
      chk("sat_p120", period_int, 120);
      chk("sat_hi_on", sat_hi, 1);
      tune(1'b1, 4'd5);
      chk("sat_hold", period_int, 120);
      repeat (7) tune(1'b0, 4'd15);
      tune(1'b0, 4'd10);
      chk("sat_p5", period_int, 5);
      chk("sat_lo_off", sat_lo, 0);
      tune(1'b0, 4'd15);
      chk("sat_p_min", period_int, 4);
      chk("sat_lo_on", sat_lo, 1);
      chk("sat_hi_clr", sat_hi, 0);
      tune(1'b0, 4'd1);
      chk("sat_min_hold", period_int, 4);
      repeat (6) tune(1'b1, 4'd15);
      tune(1'b1, 4'd6);
      chk("restore_p", period_int, 100);

      wait_tick(n);
      frac_word = 8'd128;
      step(37);
      align_en = 1'b1;
      ref_rise = 1'b1;
      step(1);
      ref_rise = 1'b0;
      chk("align_tick", dco_tick, 1);
      measure(per, hi);
      chk("align_p1", per, 100);
      frac_word = 8'd0;
      measure(per, hi);
      chk("align_p2", per, 100);
      measure(per, hi);
      chk("align_p3", per, 101);

      step(10);
      ref_period = 10'd50;
      #1;
      chk("slow_flag", ref_too_slow, 1);
      ref_rise = 1'b1;
      step(1);
      ref_rise = 1'b0;
      chk("slow_out", dco_out, 0);
      wait_tick(n);
      chk("slow_no_restart", n, 89);
      ref_period = 10'd100;
      step(1);
      chk("slow_release", dco_out, 1);
      out_en = 1'b0;
      step(1);
      chk("gate_out", dco_out, 0);
      out_en   = 1'b1;
      align_en = 1'b0;

      tune(1'b1, 4'd10);
      chk("pre_rst_p", period_int, 110);
      wait_tick(n);
      step(60);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_p", period_int, 100);
      chk("mid_rst_out", dco_out, 1);
      chk("mid_rst_tick", dco_tick, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_tick(n);
      chk("post_rst_first", n, 100);
      measure(per, hi);
      chk("post_rst_per", per, 100);
      chk("post_rst_hi", hi, 50);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
